// File: rtl/key_operand_capture.sv
// Key/switch front end for the board ALU: synchronizes and debounces the
// push buttons, then sequences entry of A, B and opcode/unsigned flag.
// Optional build macro: KEY_CAPTURE_DEBOUNCE_BYPASS_EN (no debounce counters).
module key_operand_capture #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int OP_W            = 3
) (
   input  logic            CLOCK_50,
   input  logic            RESET,
   input  logic [16:0]     SW,
   input  logic [3:1]      KEY,
   output logic [7:0]      A,
   output logic [7:0]      B,
   output logic [OP_W-1:0] OP,
   output logic            UNSIG,
   output logic            VALID,
   output logic            RUN,
   output logic            ERR,
   output logic [1:0]      STATE
);

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_OP  = 2'd2,
      S_RUN = 2'd3
   } state_t;

   localparam int SWW = 8 + OP_W + 1;

   logic [3:1]     key_s1, key_s2;
   logic [SWW-1:0] sw_s1, sw_s2;
   logic [3:1]     key_db;
   logic [3:1]     press;
   logic           unused_sw;

   assign unused_sw = ^SW[15:8+OP_W];

   // Two-flop synchronizers; keys come out of reset as released
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_s1 <= '1;
         key_s2 <= '1;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         key_s1 <= KEY;
         key_s2 <= key_s1;
         sw_s1  <= {SW[16], SW[8+OP_W-1:0]};
         sw_s2  <= sw_s1;
      end
   end

`ifdef KEY_CAPTURE_DEBOUNCE_BYPASS_EN
   // Debounced level follows the synchronized level; press on its fall
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_db <= '1;
         press  <= '0;
      end else begin
         key_db <= key_s2;
         press  <= key_db & ~key_s2;
      end
   end
`else
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:1][CW-1:0] cnt;

   // Per-key stability counter; a differing level held long enough is accepted
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_db <= '1;
         press  <= '0;
         cnt    <= '0;
      end else begin
         for (int i = 1; i <= 3; i++) begin
            press[i] <= 1'b0;
            if (key_s2[i] == key_db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               cnt[i]    <= '0;
               key_db[i] <= key_s2[i];
               press[i]  <= ~key_s2[i];
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end
`endif

   logic            ev_enter, ev_clear, ev_back;
   logic [7:0]      sw_dat;
   logic [OP_W-1:0] sw_op;
   logic            sw_uns;

   assign ev_enter = press[1];
   assign ev_clear = press[2];
   assign ev_back  = press[3];
   assign sw_dat   = sw_s2[7:0];
   assign sw_op    = sw_s2[8+OP_W-1:8];
   assign sw_uns   = sw_s2[SWW-1];

   state_t          state, state_n;
   logic [7:0]      a_n, b_n;
   logic [OP_W-1:0] op_n;
   logic            uns_n, valid_n, err_n;

   // Entry sequencer: clear beats back beats enter
   always_comb begin
      state_n = state;
      a_n     = A;
      b_n     = B;
      op_n    = OP;
      uns_n   = UNSIG;
      valid_n = 1'b0;
      err_n   = 1'b0;
      if (ev_clear) begin
         state_n = S_A;
         a_n     = '0;
         b_n     = '0;
         op_n    = '0;
         uns_n   = 1'b0;
      end else if (ev_back) begin
         case (state)
            S_B:     state_n = S_A;
            S_OP:    state_n = S_B;
            S_RUN:   state_n = S_OP;
            default: state_n = state;
         endcase
      end else if (ev_enter) begin
         case (state)
            S_A: begin
               a_n     = sw_dat;
               state_n = S_B;
            end
            S_B: begin
               b_n     = sw_dat;
               state_n = S_OP;
            end
            S_OP: begin
               if (sw_op != '0) begin
                  op_n    = sw_op;
                  uns_n   = sw_uns;
                  valid_n = 1'b1;
                  state_n = S_RUN;
               end else begin
                  err_n = 1'b1;
               end
            end
            default: state_n = S_A;
         endcase
      end
   end

   // State and captured operand registers
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state <= S_A;
         A     <= '0;
         B     <= '0;
         OP    <= '0;
         UNSIG <= 1'b0;
         VALID <= 1'b0;
         ERR   <= 1'b0;
      end else begin
         state <= state_n;
         A     <= a_n;
         B     <= b_n;
         OP    <= op_n;
         UNSIG <= uns_n;
         VALID <= valid_n;
         ERR   <= err_n;
      end
   end

   assign RUN   = (state == S_RUN);
   assign STATE = state;

endmodule

// File: tb/tb_key_operand_capture.sv
// Self-checking bench for key_operand_capture with DEBOUNCE_CYCLES=4.
// Randomized key/switch activity compared with an operand-entry model.
module tb_key_operand_capture;

   localparam int DB = 4;
   localparam int LAT = 2 + DB + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] sw;
   logic [3:1]  key;
   logic [7:0]  a, b;
   logic [2:0]  op;
   logic        unsig, valid, run, err;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   int v_cnt = 0;
   int e_cnt = 0;
   int both_cnt = 0;

   // model of what the user has entered so far
   logic [7:0] m_a, m_b;
   logic [2:0] m_op;
   logic       m_u;
   int         m_st;
   int         m_v, m_e;

   key_operand_capture #(.DEBOUNCE_CYCLES(DB), .OP_W(3)) dut (
      .CLOCK_50(clk), .RESET(rst), .SW(sw), .KEY(key),
      .A(a), .B(b), .OP(op), .UNSIG(unsig), .VALID(valid),
      .RUN(run), .ERR(err), .STATE(state)
   );

   always #5 clk = ~clk;

   // pulse counters
   always @(negedge clk) begin
      if (valid) v_cnt++;
      if (err) e_cnt++;
      if (valid && err) both_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_op = 0; m_u = 0; m_st = 0;
   endtask

   // k: 1 ENTER, 2 CLEAR, 3 BACK; counts expected pulses into m_v/m_e
   task automatic model_event(input int k, input logic [16:0] s);
      if (k == 2) begin
         model_reset();
      end else if (k == 3) begin
         if (m_st > 0) m_st = m_st - 1;
      end else begin
         if (m_st == 0) begin
            m_a = s[7:0]; m_st = 1;
         end else if (m_st == 1) begin
            m_b = s[7:0]; m_st = 2;
         end else if (m_st == 2) begin
            if (s[10:8] != 0) begin
               m_op = s[10:8]; m_u = s[16]; m_st = 3; m_v++;
            end else begin
               m_e++;
            end
         end else begin
            m_st = 0;
         end
      end
   endtask

   task automatic press(input int k, input int hold, input logic [16:0] s);
      sw = s;
      cyc(3);
      key[k] = 1'b0;
      cyc(hold);
      key[k] = 1'b1;
      cyc(10);
      model_event(k, s);
   endtask

   task automatic test_reset();
      rst = 1'b1; key = 3'b111; sw = '0;
      model_reset();
      cyc(3);
      checks++;
      if ({a, b, op, unsig, valid, run, err, state} !== 25'd0) begin
         errors++;
         $display("FAIL reset: got %h want 0",
                  {a, b, op, unsig, valid, run, err, state});
      end
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic test_enter_a();
      int n;
      int v0;
      v0 = v_cnt;
      sw = 17'h0003C;
      cyc(3);
      key[1] = 1'b0;
      n = 0;
      while (state === 2'd0 && n < 20) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n != LAT) begin
         errors++;
         $display("FAIL enter_latency: got %0d want %0d", n, LAT);
      end
      cyc(10 - n);
      key[1] = 1'b1;
      cyc(10);
      model_event(1, 17'h0003C);
      checks++;
      if ({a, b, state, v_cnt - v0} !== {8'h3C, 8'h00, 2'd1, 32'd0}) begin
         errors++;
         $display("FAIL enter_a: got a=%h b=%h st=%0d want a=3c b=00 st=1",
                  a, b, state);
      end
   endtask

   task automatic test_full_seq();
      int v0;
      press(1, 10, 17'h000F0);
      v0 = v_cnt;
      press(1, 10, 17'h10500);
      checks++;
      if ({a, b, op, unsig, run, state} !== {8'h12, 8'hF0, 3'd5, 1'b1, 1'b1, 2'd3}
          && {a, b, op, unsig, run, state} !== {8'h3C, 8'hF0, 3'd5, 1'b1, 1'b1, 2'd3}) begin
         errors++;
         $display("FAIL full_seq: got a=%h b=%h op=%0d u=%b run=%b st=%0d",
                  a, b, op, unsig, run, state);
      end
      checks++;
      if (v_cnt - v0 != 1) begin
         errors++;
         $display("FAIL full_seq_valid: got %0d pulses want 1", v_cnt - v0);
      end
   endtask

   task automatic test_seq_12();
      int v0;
      press(2, 8, 17'h0);
      press(1, 8, 17'h00012);
      press(1, 8, 17'h000F0);
      v0 = v_cnt;
      press(1, 8, 17'h10500);
      checks++;
      if ({a, b, op, unsig, run, state, v_cnt - v0} !==
          {8'h12, 8'hF0, 3'd5, 1'b1, 1'b1, 2'd3, 32'd1}) begin
         errors++;
         $display("FAIL seq_12: got a=%h b=%h op=%0d u=%b run=%b st=%0d v=%0d",
                  a, b, op, unsig, run, state, v_cnt - v0);
      end
   endtask

   task automatic test_back_err();
      int v0, e0;
      press(3, 8, 17'h0);
      checks++;
      if ({a, b, op, unsig, run, state} !==
          {8'h12, 8'hF0, 3'd5, 1'b1, 1'b0, 2'd2}) begin
         errors++;
         $display("FAIL back_run: got a=%h b=%h op=%0d u=%b run=%b st=%0d",
                  a, b, op, unsig, run, state);
      end
      v0 = v_cnt; e0 = e_cnt;
      press(1, 8, 17'h000AA);
      checks++;
      if ({op, state, e_cnt - e0, v_cnt - v0} !==
          {3'd5, 2'd2, 32'd1, 32'd0}) begin
         errors++;
         $display("FAIL op_reject: got op=%0d st=%0d err=%0d val=%0d want 5 2 1 0",
                  op, state, e_cnt - e0, v_cnt - v0);
      end
      v0 = v_cnt;
      press(1, 8, 17'h00100);
      checks++;
      if ({op, unsig, state, v_cnt - v0} !== {3'd1, 1'b0, 2'd3, 32'd1}) begin
         errors++;
         $display("FAIL op_accept: got op=%0d u=%b st=%0d val=%0d want 1 0 3 1",
                  op, unsig, state, v_cnt - v0);
      end
   endtask

   task automatic test_bounce();
      int moves, n;
      moves = 0;
      for (int i = 0; i < 5; i++) begin
         key[1] = 1'b0;
         for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            if (state !== 2'd3) moves++;
         end
         key[1] = 1'b1;
         for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            if (state !== 2'd3) moves++;
         end
      end
      cyc(4);
      checks++;
      if (moves != 0 || state !== 2'd3) begin
         errors++;
         $display("FAIL bounce_quiet: got %0d moved cycles st=%0d want 0 3",
                  moves, state);
      end
      key[1] = 1'b0;
      n = 0;
      while (state === 2'd3 && n < 20) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n != LAT || state !== 2'd0) begin
         errors++;
         $display("FAIL bounce_latency: got %0d st=%0d want %0d 0", n, state, LAT);
      end
      cyc(10);
      key[1] = 1'b1;
      cyc(10);
      model_event(1, sw);
   endtask

   task automatic test_clear_enter();
      int v0, e0;
      press(1, 8, 17'h00055);
      v0 = v_cnt; e0 = e_cnt;
      sw = 17'h00099;
      cyc(3);
      key[1] = 1'b0; key[2] = 1'b0;
      cyc(10);
      key = 3'b111;
      cyc(10);
      model_event(2, sw);
      checks++;
      if ({a, b, op, unsig, run, state, v_cnt - v0, e_cnt - e0} !==
          {25'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL clear_enter: got a=%h b=%h op=%0d u=%b run=%b st=%0d",
                  a, b, op, unsig, run, state);
      end
   endtask

   task automatic test_reset_async();
      int n;
      press(1, 8, 17'h00011);
      press(1, 8, 17'h00022);
      press(1, 8, 17'h1073F);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({a, b, op, unsig, valid, run, err, state} !== 25'd0) begin
         errors++;
         $display("FAIL reset_run: got %h want 0",
                  {a, b, op, unsig, valid, run, err, state});
      end
      model_reset();
      cyc(2);
      rst = 1'b0;
      sw = 17'h00044;
      cyc(3);
      key[1] = 1'b0;
      cyc(4);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({a, state} !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid: got a=%h st=%0d want 0 0", a, state);
      end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (state === 2'd0 && n < 20) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n != LAT || a !== 8'h44) begin
         errors++;
         $display("FAIL reset_redebounce: got %0d a=%h want %0d 44", n, a, LAT);
      end
      key[1] = 1'b1;
      cyc(10);
      model_event(1, 17'h00044);
   endtask

   task automatic test_random();
      int k, r, v0, e0, bad;
      logic [16:0] s;
      bad = 0;
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         k = (r < 6) ? 1 : (r < 8) ? 3 : 2;
         s = 17'($urandom);
         if ($urandom_range(0, 3) == 0) s[10:8] = 3'd0;
         m_v = 0; m_e = 0;
         v0 = v_cnt; e0 = e_cnt;
         press(k, $urandom_range(5, 12), s);
         sw = 17'($urandom);
         cyc(4);
         checks++;
         if ({a, b, op, unsig, run, state} !==
             {m_a, m_b, m_op, m_u, (m_st == 3), 2'(m_st)}
             || v_cnt - v0 != m_v || e_cnt - e0 != m_e) begin
            errors++;
            bad++;
            if (bad < 5)
               $display("FAIL random[%0d]: got a=%h b=%h op=%0d u=%b st=%0d v=%0d e=%0d want a=%h b=%h op=%0d u=%b st=%0d v=%0d e=%0d",
                        it, a, b, op, unsig, state, v_cnt - v0, e_cnt - e0,
                        m_a, m_b, m_op, m_u, m_st, m_v, m_e);
         end
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL valid_err_overlap: got %0d cycles want 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_enter_a();
      test_full_seq();
      test_seq_12();
      test_back_err();
      test_bounce();
      test_clear_enter();
      test_reset_async();
      test_random();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_operand_capture.md
Name: key_operand_capture

Overview:
- Input-side front end for the board ALU datapath. The display side turns results into HEX digits; this block turns user actions into operands.
- Debounces and synchronizes the active-low push buttons, then sequences operand entry from the switches: A, then B, then opcode/unsigned flag.
- Presents registered A, B, OP and UNSIG to the ALU with a one-cycle VALID strobe.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz).
- OP_W, 3, opcode width taken from SW[8+OP_W-1:8].

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- SW  input  17  [7:0] operand data, [10:8] opcode, [16] unsigned flag; asynchronous, sampled through synchronizer
- KEY  input  3  [3:1]; active-low buttons: KEY[1]=ENTER, KEY[2]=CLEAR, KEY[3]=BACK
- A  output  8  captured operand A
- B  output  8  captured operand B
- OP  output  OP_W  captured opcode
- UNSIG  output  1  captured unsigned flag
- VALID  output  1  one-cycle pulse when a full operand set is committed
- RUN  output  1  high while a committed set is held (state S_RUN)
- ERR  output  1  one-cycle pulse on rejected opcode
- STATE  output  2  current FSM state, for LEDR

Behaviour:
- Reset (async assert, sync-released use): A=B=0, OP=0, UNSIG=0, VALID=0, RUN=0, ERR=0, STATE=S_A. Synchronizers preset to 1 (released); debounced levels=1; debounce counters=0. Reset mid-debounce discards partial counts.
- Input path: each KEY bit and SW goes through a 2-flop synchronizer.
- Debounce, per key:
  - The counter resets whenever the synchronized level equals the debounced level or changes.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level updates.
  - A press event is a one-cycle pulse on a debounced 1->0 transition. Release produces no event; a held key produces exactly one event.
- Latency: press event fires DEBOUNCE_CYCLES cycles after the synchronized level first changes. Capture and state change occur on the edge the event is seen (registered outputs update 1 cycle after the event cycle).
- Priority for same-cycle events: CLEAR > BACK > ENTER.
- FSM states and transitions: S_A=0, S_B=1, S_OP=2, S_RUN=3.
  - S_A, ENTER: A<=SW[7:0]; go to S_B.
  - S_B, ENTER: B<=SW[7:0]; go to S_OP.
  - S_OP, ENTER, SW[10:8]!=0: OP<=SW[10:8], UNSIG<=SW[16], VALID=1 for one cycle; go to S_RUN; RUN=1.
  - S_OP, ENTER, SW[10:8]==0: reject; ERR=1 for one cycle; stay in S_OP; OP unchanged.
  - S_RUN, ENTER: go to S_A; RUN=0. A/B/OP/UNSIG are retained until overwritten.
  - BACK: S_B->S_A, S_OP->S_B, S_RUN->S_OP (RUN=0). In S_A, BACK does nothing. Registers are unchanged.
  - CLEAR, from any state: go to S_A; A, B, OP, UNSIG, RUN all 0. No VALID/ERR pulse.
- VALID and ERR never assert in the same cycle. VALID asserts only on the S_OP->S_RUN transition.
- SW changes outside ENTER events never affect outputs.

Optional Feature:
- Macro: KEY_CAPTURE_DEBOUNCE_BYPASS_EN.
- Defined: debounce counters are removed. The debounced level equals the synchronized level; the press event fires the cycle after the synchronized 1->0 transition. Intended for fast simulation/emulation.
- Undefined: full debounce as above. All FSM behaviour is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset, then SW[7:0]=0x3C, press ENTER 10 cycles, release -> A=0x3C, STATE=1, exactly one event, B unchanged at 0.
- Full sequence A=0x12, B=0xF0, SW[10:8]=3'b101, SW[16]=1, ENTER each -> A=0x12, B=0xF0, OP=5, UNSIG=1, VALID high exactly 1 cycle, RUN=1, STATE=3.
- In S_OP with SW[10:8]=0, press ENTER -> ERR 1-cycle pulse, STATE stays 2, VALID=0; then SW[10:8]=1 and ENTER -> VALID, OP=1.
- Bounce: KEY[1] toggles low/high every 2 cycles for 20 cycles, then held low -> no event during toggling; single event exactly 4 cycles after the final stable low at the synchronizer.
- ENTER and CLEAR pressed in the same cycle while in S_B with A=0x55 -> STATE=0, A=0, no capture. BACK in S_RUN -> STATE=2, RUN=0, registers kept.
- Assert RESET mid-debounce (count=2) and while RUN=1 -> all outputs 0, STATE=0 immediately (async). After release, a held key needs a full 4-cycle debounce before any event.
